// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for a classic multicycle MIPS-style datapath. It walks each
// instruction through FETCH, DECODE and the execute/memory/writeback states for
// its class, and stalls in the memory states until the memory reports ready.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   reset        asynchronous, active-high; returns the FSM to FETCH at once
//   opcode[5:0]  instruction opcode from the IR, valid from DECODE onward
//   mem_ready    memory handshake, 1 = the access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA   datapath strobes / selects
//   ALUSrcB[1:0] 00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   ALUOp[2:0]   000 add, 001 sub, 010 decode from funct
//   PCSource[1:0] 00 ALU result, 01 ALUOut register, 10 jump target
//   illegal      one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0]   current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur;

    // Opcode is one of the six instruction classes this controller executes.
    logic supported_op;
    assign supported_op = (opcode == OP_RTYPE) || (opcode == OP_LW) ||
                          (opcode == OP_SW)    || (opcode == OP_BEQ) ||
                          (opcode == OP_ADDI)  || (opcode == OP_J);

    // NOTE: state is updated with non-blocking assignments so every reader in
    // the same edge sees the pre-edge value; blocking here would race.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:  if (mem_ready) cur <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_RTYPE:     cur <= EXEC;
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_BEQ:       cur <= BRANCH;
                        OP_ADDI:      cur <= ADDIEX;
                        OP_J:         cur <= JUMP;
                        default:      cur <= FETCH;
                    endcase
                end
                MEMADR: cur <= (opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD:  if (mem_ready) cur <= MEMWB;
                MEMWB:  cur <= FETCH;
                MEMWR:  if (mem_ready) cur <= FETCH;
                EXEC:   cur <= ALUWB;
                ALUWB:  cur <= FETCH;
                BRANCH: cur <= FETCH;
                ADDIEX: cur <= ADDIWB;
                ADDIWB: cur <= FETCH;
                JUMP:   cur <= FETCH;
                // Unused codes 12-15 recover to FETCH.
                default: cur <= FETCH;
            endcase
        end
    end

    assign state = cur;

    // Outputs are Moore-decoded from the state; only the FETCH write strobes
    // look at mem_ready so the IR and PC are written exactly when the
    // instruction fetch completes. Since reset forces cur to FETCH
    // asynchronously, the FETCH decode also appears immediately on reset.
    //
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned; a missing default here would infer a latch.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        PCSource    = 2'b00;
        illegal     = 1'b0;

        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;          // PC + 4
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB = 2'b11;          // precompute branch target
                illegal = ~supported_op;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed-vector bench for multicycle_control. The stimulus process drives
// opcode/mem_ready once per cycle and queues the hand-derived state and control
// word expected for that cycle; a monitor pops and compares mid-cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        int         id;
        logic [3:0] st;
        ctrl_t      c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal;
    logic [3:0] state;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal     (illegal),
        .state       (state)
    );

    always #5 clk = ~clk;

    ctrl_t act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  PCSource, illegal};

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   vec_id = 0;

    // Expected control words, one per state (and per mem_ready where it matters).
    ctrl_t e_fetch_wait, e_fetch_rdy, e_decode, e_decode_ill, e_memadr, e_memrd;
    ctrl_t e_memwb, e_memwr, e_exec, e_aluwb, e_branch, e_addiex, e_addiwb, e_jump;

    task automatic check(input int id, input logic [3:0] st_a, input logic [3:0] st_e,
                         input ctrl_t c_a, input ctrl_t c_e);
        n_vec++;
        if (st_a !== st_e || c_a !== c_e) begin
            n_miss++;
            $display("FAIL vec%0d: got state=%0d ctrl=%05h, want state=%0d ctrl=%05h",
                     id, st_a, c_a, st_e, c_e);
        end
    endtask

    // One cycle of stimulus plus the response expected while it is applied.
    task automatic step(input logic [5:0] op, input logic mr,
                        input logic [3:0] es, input ctrl_t ec);
        exp_t e;
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = mr;
        vec_id++;
        e.id = vec_id;
        e.st = es;
        e.c  = ec;
        sb.push_back(e);
    endtask

    // Monitor: compares mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.id, state, e.st, act, e.c);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        e_fetch_wait = '0; e_fetch_wait.mem_read = 1'b1; e_fetch_wait.alu_src_b = 2'b01;
        e_fetch_rdy  = e_fetch_wait; e_fetch_rdy.ir_write = 1'b1; e_fetch_rdy.pc_write = 1'b1;
        e_decode     = '0; e_decode.alu_src_b = 2'b11;
        e_decode_ill = e_decode; e_decode_ill.illegal = 1'b1;
        e_memadr     = '0; e_memadr.alu_src_a = 1'b1; e_memadr.alu_src_b = 2'b10;
        e_memrd      = '0; e_memrd.mem_read = 1'b1; e_memrd.i_or_d = 1'b1;
        e_memwb      = '0; e_memwb.reg_write = 1'b1; e_memwb.mem_to_reg = 1'b1;
        e_memwr      = '0; e_memwr.mem_write = 1'b1; e_memwr.i_or_d = 1'b1;
        e_exec       = '0; e_exec.alu_src_a = 1'b1; e_exec.alu_op = 3'b010;
        e_aluwb      = '0; e_aluwb.reg_write = 1'b1; e_aluwb.reg_dst = 1'b1;
        e_branch     = '0; e_branch.alu_src_a = 1'b1; e_branch.alu_op = 3'b001;
        e_branch.pc_write_cond = 1'b1; e_branch.pc_source = 2'b01;
        e_addiex     = '0; e_addiex.alu_src_a = 1'b1; e_addiex.alu_src_b = 2'b10;
        e_addiwb     = '0; e_addiwb.reg_write = 1'b1;
        e_jump       = '0; e_jump.pc_write = 1'b1; e_jump.pc_source = 2'b10;

        // Reset held across edges: FETCH decode with mem_ready low.
        reset     = 1'b1;
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check(0, state, 4'd0, act, e_fetch_wait);
        #1 reset = 1'b0;

        // R-type: 0,1,6,7
        step(6'b000000, 1'b1, 4'd0,  e_fetch_rdy);
        step(6'b000000, 1'b1, 4'd1,  e_decode);
        step(6'b000000, 1'b1, 4'd6,  e_exec);
        step(6'b000000, 1'b1, 4'd7,  e_aluwb);
        // lw with a FETCH stall and a 2-cycle MEMRD stall: 0,0,1,2,3,3,3,4
        step(6'b100011, 1'b0, 4'd0,  e_fetch_wait);
        step(6'b100011, 1'b1, 4'd0,  e_fetch_rdy);
        step(6'b100011, 1'b1, 4'd1,  e_decode);
        step(6'b100011, 1'b1, 4'd2,  e_memadr);
        step(6'b100011, 1'b0, 4'd3,  e_memrd);
        step(6'b100011, 1'b0, 4'd3,  e_memrd);
        step(6'b100011, 1'b1, 4'd3,  e_memrd);
        step(6'b100011, 1'b1, 4'd4,  e_memwb);
        // sw: 0,1,2,5
        step(6'b101011, 1'b1, 4'd0,  e_fetch_rdy);
        step(6'b101011, 1'b1, 4'd1,  e_decode);
        step(6'b101011, 1'b1, 4'd2,  e_memadr);
        step(6'b101011, 1'b1, 4'd5,  e_memwr);
        // beq: 0,1,8
        step(6'b000100, 1'b1, 4'd0,  e_fetch_rdy);
        step(6'b000100, 1'b1, 4'd1,  e_decode);
        step(6'b000100, 1'b1, 4'd8,  e_branch);
        // j: 0,1,11
        step(6'b000010, 1'b1, 4'd0,  e_fetch_rdy);
        step(6'b000010, 1'b1, 4'd1,  e_decode);
        step(6'b000010, 1'b1, 4'd11, e_jump);
        // addi: 0,1,9,10
        step(6'b001000, 1'b1, 4'd0,  e_fetch_rdy);
        step(6'b001000, 1'b1, 4'd1,  e_decode);
        step(6'b001000, 1'b1, 4'd9,  e_addiex);
        step(6'b001000, 1'b1, 4'd10, e_addiwb);
        // illegal opcode: 0,1(illegal),0
        step(6'b111111, 1'b1, 4'd0,  e_fetch_rdy);
        step(6'b111111, 1'b1, 4'd1,  e_decode_ill);
        step(6'b111111, 1'b0, 4'd0,  e_fetch_wait);
        // sw stalled in MEMWR, then reset pulsed mid-cycle
        step(6'b101011, 1'b1, 4'd0,  e_fetch_rdy);
        step(6'b101011, 1'b1, 4'd1,  e_decode);
        step(6'b101011, 1'b1, 4'd2,  e_memadr);
        step(6'b101011, 1'b0, 4'd5,  e_memwr);
        #5;
        reset = 1'b1;
        #1;
        check(100, state, 4'd0, act, e_fetch_wait);
        #1 reset = 1'b0;
        // Abandoned store: no MemWrite until a fresh sw reaches MEMWR.
        step(6'b101011, 1'b0, 4'd0,  e_fetch_wait);
        step(6'b101011, 1'b0, 4'd0,  e_fetch_wait);
        step(6'b101011, 1'b1, 4'd0,  e_fetch_rdy);
        step(6'b101011, 1'b1, 4'd1,  e_decode);
        step(6'b101011, 1'b1, 4'd2,  e_memadr);
        step(6'b101011, 1'b1, 4'd5,  e_memwr);
        step(6'b000000, 1'b0, 4'd0,  e_fetch_wait);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expected entries never compared, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces state FETCH immediately.
REQ-004 opcode  input  6  instruction opcode, valid from DECODE onward (IR held by datapath).
REQ-005 mem_ready  input  1  memory handshake; 1 = access completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath strobes/selects.
REQ-007 ALUSrcB  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-008 ALUOp  output  3  000 add, 001 sub, 010 decode from funct.
REQ-009 PCSource  output  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-010 illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-011 state  output  4  current state encoding, for debug and bench.

Function
REQ-012 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 unused, each goes to FETCH on the next edge with all outputs 0.
REQ-013 All outputs are Moore-decoded from state, except where gated by mem_ready (REQ-014/015); any strobe not listed for a state is 0.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=PCWrite=mem_ready; stays in FETCH while mem_ready=0, goes to DECODE when mem_ready=1.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target precompute). Next state by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, any other->FETCH with illegal=1 during DECODE.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Goes to MEMRD if opcode=100011, else MEMWR.
REQ-017 MEMRD: MemRead=1, IorD=1. Held while mem_ready=0; goes to MEMWB when mem_ready=1.
REQ-018 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; next FETCH.
REQ-019 MEMWR: MemWrite=1, IorD=1. Held while mem_ready=0; goes to FETCH when mem_ready=1.
REQ-020 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010; next ALUWB. ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01; next FETCH.
REQ-022 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=000; next ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-023 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-024 Cycle counts with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2; each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
REQ-025 MemRead and MemWrite are never both 1; PCWrite and PCWriteCond are never both 1.

Reset
REQ-026 reset=1 asynchronously sets state=FETCH; while reset is held, all outputs are 0 except the FETCH decodes of REQ-014.
REQ-027 Reset asserted in any state, including mid-MEMRD or MEMWR stall, abandons the instruction; no RegWrite or MemWrite pulse follows the deassertion.
REQ-028 After reset deasserts, the first state-changing rising edge is evaluated as FETCH.

Verification
REQ-029 reset, then opcode=000000, mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7; ALUOp=010 in state 6.
REQ-030 opcode=100011, mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemRead=1, IorD=1 throughout state 3; RegWrite=1, MemtoReg=1 in state 4.
REQ-031 opcode=101011, then opcode=000100 -> sw: 0,1,2,5,0 with MemWrite=1 in state 5; beq: 0,1,8,0 with PCWriteCond=1, ALUOp=001, PCSource=01 in state 8.
REQ-032 opcode=000010, then opcode=001000 -> j: 0,1,11,0 with PCWrite=1, PCSource=10; addi: 0,1,9,10,0 with RegWrite=1, RegDst=0 in state 10.
REQ-033 opcode=111111 -> states 0,1,0; illegal=1 for exactly the DECODE cycle; no RegWrite, MemWrite or PCWrite outside FETCH.
REQ-034 reset pulsed mid-cycle during MEMWR stall (mem_ready=0) -> state=0 before the next edge, MemWrite=0, and MemWrite stays 0 until a new sw reaches state 5.
